// File: rtl/acorn_su_par.sv
// acorn_su_par: ACORN-128 state-update engine, W steps per accepted word.
//
// Each valid/ready transfer runs W ACORN steps (combinationally unrolled)
// on the 293-bit state. Message bit j drives step j (LSB first). The
// keystream bits and in_data ^ ks are held in an output register that
// drains through out_valid/out_ready.
//
// Parameters:
//   W      steps per word, 1..64
//   CNT_W  width of the step counter
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   load, state_in       overwrite state and clear counter (beats in_valid)
//   in_valid, in_ready   input handshake
//   in_data              message word
//   in_ca, in_cb         ACORN control bits for all W steps of the word
//   in_dec               0 = encrypt, 1 = decrypt feedback
//   out_valid, out_ready output handshake
//   out_data, out_ks     in_data ^ ks and raw keystream of the last word
//   state_out            current state register
//   step_cnt             steps processed since reset or load (wraps)
module acorn_su_par #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [292:0]       state_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               in_ca,
    input  logic               in_cb,
    input  logic               in_dec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [W-1:0]       out_ks,
    output logic [292:0]       state_out,
    output logic [CNT_W-1:0]   step_cnt
);

    generate
        if (W == 0 || W > 64) begin : g_bad_w
            $error("acorn_su_par: W must be within 1..64");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    ostate_t            os_q;
    ostate_t            os_d;
    logic [292:0]       state_q;
    logic [W-1:0]       data_q;
    logic [W-1:0]       ks_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [292:0]       nxt_state;
    logic [W-1:0]       ks_vec;
    logic               xfer;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic a, input logic b, input logic c);
        return (a & b) ^ (~a & c);
    endfunction

    // Returns {ks, next_state}. The six LFSR folds run in sequence, so
    // S289 sees the old S230, S230 the old S193, and so on down the chain.
    function automatic logic [293:0] acorn_step(
        input logic [292:0] s_in,
        input logic         ca,
        input logic         cb,
        input logic         x,
        input logic         dec
    );
        logic [292:0] s;
        logic         ks;
        logic         f;
        logic         m;
        s      = s_in;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
        f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
        m  = dec ? (x ^ ks) : x;
        return {ks, f ^ m, s[292:1]};
    endfunction

    // W steps chained within one cycle.
    always_comb begin : p_unroll
        logic [293:0] r;
        r         = '0;
        nxt_state = state_q;
        ks_vec    = '0;
        for (int unsigned j = 0; j < W; j++) begin
            r         = acorn_step(nxt_state, in_ca, in_cb, in_data[j], in_dec);
            nxt_state = r[292:0];
            ks_vec[j] = r[293];
        end
    end

    assign in_ready = !load && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            data_q  <= '0;
            ks_q    <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            state_q <= state_in;
            cnt_q   <= '0;
        end else if (xfer) begin
            state_q <= nxt_state;
            data_q  <= in_data ^ ks_vec;
            ks_q    <= ks_vec;
            cnt_q   <= cnt_q + CNT_W'(W);
        end
    end

    // Output-register FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_q <= EMPTY;
        end else begin
            os_q <= os_d;
        end
    end

    // Output-register FSM: next state; load drops any held word
    always_comb begin
        os_d = os_q;
        if (load) begin
            os_d = EMPTY;
        end else begin
            case (os_q)
                EMPTY:   if (xfer) os_d = FULL;
                FULL:    if (!xfer && out_ready) os_d = EMPTY;
                default: os_d = EMPTY;
            endcase
        end
    end

    // Output-register FSM: outputs
    always_comb begin
        out_valid = (os_q == FULL);
    end

    assign out_data  = data_q;
    assign out_ks    = ks_q;
    assign state_out = state_q;
    assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_acorn_su_par.sv
module tb_acorn_su_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_ca, in_cb, in_dec;
    logic [292:0] state_in;

    logic         load8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]   in_data8, out_data8, out_ks8;
    logic [292:0] state_out8;
    logic [31:0]  step_cnt8;

    logic         load1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0]   in_data1, out_data1, out_ks1;
    logic [292:0] state_out1;
    logic [31:0]  step_cnt1;

    acorn_su_par #(.W(8), .CNT_W(32)) dut8 (
        .clk(clk), .rst(rst), .load(load8), .state_in(state_in),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_ca(in_ca), .in_cb(in_cb), .in_dec(in_dec),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_ks(out_ks8), .state_out(state_out8), .step_cnt(step_cnt8)
    );

    acorn_su_par #(.W(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .state_in(state_in),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .in_ca(in_ca), .in_cb(in_cb), .in_dec(in_dec),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_ks(out_ks1), .state_out(state_out1), .step_cnt(step_cnt1)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] ks;
    } res_t;

    res_t         q8[$], q1[$];
    res_t         cur8, cur1;
    logic [292:0] m8_st, m1_st;
    logic [31:0]  m8_cnt, m1_cnt;
    bit           v8, v1;
    int           n_assert = 0;
    int           n_fail = 0;
    int           delivered8 = 0;
    int           accepted8 = 0;

    function automatic logic maj_m(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic ch_m(input logic a, input logic b, input logic c);
        return a ? b : c;
    endfunction

    function automatic logic [292:0] mstep(input logic [292:0] st, input logic ca,
                                           input logic cb, input logic x,
                                           input logic dec, output logic ks);
        logic [292:0] s;
        logic         f;
        s = st;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66] ^ s[61];
        s[61]  = s[61] ^ s[23] ^ s[0];
        ks = s[12] ^ s[154] ^ maj_m(s[235], s[61], s[193]) ^ ch_m(s[230], s[111], s[66]);
        f  = s[0] ^ ~s[107] ^ maj_m(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
        return {f ^ x ^ (dec & ks), s[292:1]};
    endfunction

    function automatic logic [292:0] mword(input logic [292:0] st, input int unsigned w,
                                           input logic [63:0] x, input logic ca,
                                           input logic cb, input logic dec,
                                           output logic [63:0] ks, output logic [63:0] od);
        logic [292:0] s;
        logic         k;
        s  = st;
        ks = '0;
        od = '0;
        for (int unsigned j = 0; j < w; j++) begin
            s     = mstep(s, ca, cb, x[j], dec, k);
            ks[j] = k;
            od[j] = x[j] ^ k;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict handshake and results, push expectations, then
    // check everything just after the edge.
    task automatic step();
        bit          rdy8, rdy1, acc8, acc1;
        res_t        r;
        logic [63:0] k, d;
        @(negedge clk);
        rdy8 = !load8 && (!v8 || out_ready8);
        rdy1 = !load1 && (!v1 || out_ready1);
        acc8 = rdy8 && in_valid8;
        acc1 = rdy1 && in_valid1;
        chk("in_ready8", 293'(in_ready8), 293'(rdy8));
        chk("in_ready1", 293'(in_ready1), 293'(rdy1));
        if (out_valid8 && out_ready8) delivered8++;
        if (acc8) accepted8++;
        if (load8) begin
            m8_st = state_in; m8_cnt = '0; v8 = 1'b0;
        end else if (acc8) begin
            m8_st = mword(m8_st, 8, 64'(in_data8), in_ca, in_cb, in_dec, k, d);
            r.data = d; r.ks = k; q8.push_back(r);
            m8_cnt = m8_cnt + 32'd8; v8 = 1'b1;
        end else if (out_ready8) begin
            v8 = 1'b0;
        end
        if (load1) begin
            m1_st = state_in; m1_cnt = '0; v1 = 1'b0;
        end else if (acc1) begin
            m1_st = mword(m1_st, 1, 64'(in_data1), in_ca, in_cb, in_dec, k, d);
            r.data = d; r.ks = k; q1.push_back(r);
            m1_cnt = m1_cnt + 32'd1; v1 = 1'b1;
        end else if (out_ready1) begin
            v1 = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid8", 293'(out_valid8), 293'(v8));
        if (acc8) begin
            n_assert++;
            assert (q8.size() > 0) else begin
                n_fail++; $error("FAIL sb8_empty: observed 0 entries expected 1");
            end
            if (q8.size() > 0) cur8 = q8.pop_front();
        end
        if (v8) begin
            chk("out_data8", 293'(out_data8), 293'(cur8.data[7:0]));
            chk("out_ks8", 293'(out_ks8), 293'(cur8.ks[7:0]));
        end
        chk("state8", state_out8, m8_st);
        chk("cnt8", 293'(step_cnt8), 293'(m8_cnt));
        chk("out_valid1", 293'(out_valid1), 293'(v1));
        if (acc1) begin
            n_assert++;
            assert (q1.size() > 0) else begin
                n_fail++; $error("FAIL sb1_empty: observed 0 entries expected 1");
            end
            if (q1.size() > 0) cur1 = q1.pop_front();
        end
        if (v1) begin
            chk("out_data1", 293'(out_data1), 293'(cur1.data[0]));
            chk("out_ks1", 293'(out_ks1), 293'(cur1.ks[0]));
        end
        chk("state1", state_out1, m1_st);
        chk("cnt1", 293'(step_cnt1), 293'(m1_cnt));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state8"}, state_out8, '0);
        chk({tag, "_cnt8"}, 293'(step_cnt8), '0);
        chk({tag, "_valid8"}, 293'(out_valid8), '0);
        chk({tag, "_data8"}, 293'(out_data8), '0);
        chk({tag, "_ks8"}, 293'(out_ks8), '0);
        chk({tag, "_state1"}, state_out1, '0);
        chk({tag, "_cnt1"}, 293'(step_cnt1), '0);
        chk({tag, "_valid1"}, 293'(out_valid1), '0);
    endtask

    task automatic model_reset();
        m8_st = '0; m8_cnt = '0; v8 = 1'b0; q8.delete();
        m1_st = '0; m1_cnt = '0; v1 = 1'b0; q1.delete();
        cur8.data = '0; cur8.ks = '0; cur1.data = '0; cur1.ks = '0;
    endtask

    initial begin
        logic [292:0] top1, ff8, a58;
        logic [31:0]  w;
        top1 = '0; top1[292] = 1'b1;
        ff8  = '0; ff8[292:285] = 8'hFF;
        a58  = '0; a58[292:285] = 8'hA5;

        rst = 1'b0; in_ca = 1'b1; in_cb = 1'b1; in_dec = 1'b0; state_in = '0;
        load8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        load1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // zero state, encrypt, all-zero input, W=1 and W=8 side by side
        in_valid8 = 1'b1; in_data8 = 8'h00;
        in_valid1 = 1'b1; in_data1 = 1'b0;
        step();
        in_valid8 = 1'b0; in_valid1 = 1'b0;
        chk("w1_ks", 293'(out_ks1), '0);
        chk("w1_data", 293'(out_data1), '0);
        chk("w1_state", state_out1, top1);
        chk("w1_cnt", 293'(step_cnt1), 293'(1));
        chk("w8_state", state_out8, ff8);
        chk("w8_ks", 293'(out_ks8), '0);
        chk("w8_cnt", 293'(step_cnt8), 293'(8));

        // back to zero state via load (discards held word), then decrypt 0x5A
        load8 = 1'b1; state_in = '0;
        step();
        load8 = 1'b0;
        in_dec = 1'b1; in_valid8 = 1'b1; in_data8 = 8'h5A;
        step();
        in_valid8 = 1'b0; in_dec = 1'b0;
        chk("dec_data", 293'(out_data8), 293'(8'h5A));
        chk("dec_state", state_out8, a58);

        // load with concurrent in_valid: word must not be consumed
        for (int i = 0; i < 293; i++) state_in[i] = 1'($urandom);
        load8 = 1'b1; in_valid8 = 1'b1; in_data8 = 8'($urandom);
        load1 = 1'b1;
        step();
        chk("ld_state", state_out8, state_in);
        chk("ld_cnt", 293'(step_cnt8), '0);
        chk("ld_valid", 293'(out_valid8), '0);
        load8 = 1'b0; load1 = 1'b0; in_valid8 = 1'b0;

        // random words: W=8 one word per cycle vs W=1 bit-serial
        for (int i = 0; i < 200; i++) begin
            w = $urandom;
            in_ca = w[8]; in_cb = w[9]; in_dec = w[10];
            for (int j = 0; j < 8; j++) begin
                in_valid8 = (j == 0);
                in_data8  = w[7:0];
                in_valid1 = 1'b1;
                in_data1  = w[j];
                step();
            end
        end
        in_valid8 = 1'b0; in_valid1 = 1'b0;
        in_ca = 1'b1; in_cb = 1'b1; in_dec = 1'b0;

        // backpressure from zero state
        load8 = 1'b1; state_in = '0;
        step();
        load8 = 1'b0;
        delivered8 = 0; accepted8 = 0;
        out_ready8 = 1'b0; in_valid8 = 1'b1; in_data8 = 8'h00;
        step();
        in_data8 = 8'h33;
        repeat (3) step();
        out_ready8 = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            in_data8 = 8'($urandom);
            step();
        end
        in_valid8 = 1'b0;
        step();
        chk("deliveries", 293'(delivered8), 293'(accepted8));

        // reset mid-stream, then accept on the first edge after release
        in_valid8 = 1'b1; in_data8 = 8'($urandom);
        step();
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        #1;
        rst = 1'b1;
        in_data8 = 8'h00;
        step();
        in_valid8 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/acorn_su_par.md
# acorn_su_par

Parametrised ACORN-128 state-update engine that advances the 293-bit cipher state by W steps per clock. It consumes one W-bit message word per valid/ready transfer and returns the W-bit keystream-combined result plus raw keystream. It supports encrypt and decrypt feedback, has a state load port, and counts steps. It sits between the ACORN phase controller (init / AD / text / finalise) and the data path, and replaces the single-step update used so far.

## Interface
- W, default 8: steps per accepted word, legal 1..64; other values must fail elaboration.
- CNT_W, default 32: width of the step counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  replace state with state_in; priority over in_valid.
- state_in  in  293  state value written on load.
- in_valid  in  1  word available.
- in_ready  out  1  engine accepts word this cycle.
- in_data  in  W  message word, bit j is processed at step j (LSB first).
- in_ca, in_cb  in  1 each  ACORN control bits, applied to all W steps of the word.
- in_dec  in  1  0 = encrypt (feedback m = in_data), 1 = decrypt (feedback m = in_data ^ ks).
- out_valid  out  1  result word held.
- out_ready  in  1  consumer takes result.
- out_data  out  W  in_data ^ ks.
- out_ks  out  W  keystream bits, bit j from step j.
- state_out  out  293  current state register.
- step_cnt  out  CNT_W  steps processed since reset or load.

## Operation
- One ACORN step on state S with control bits ca and cb, and input bit x:
  - S289^=S235^S230
  - S230^=S196^S193
  - S193^=S160^S154
  - S154^=S111^S107
  - S107^=S66^S61
  - S61^=S23^S0
  - Then ks = S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66).
  - Then f = S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks).
  - Then shift S[i]=S[i+1] for i=0..291, and set S292 = f^m.
- maj(a,b,c) = ab^ac^bc; ch(a,b,c) = ab^~a·c.
- m = x when encrypting; m = x^ks when decrypting.
- A transfer (in_valid & in_ready & !load) applies W steps sequentially, combinationally unrolled, in one cycle.
  - State, out_data, out_ks and step_cnt update on that edge.
  - out_valid is set on that edge.
- step_cnt adds W per transfer and wraps modulo 2^CNT_W.
- Load:
  - state ← state_in and step_cnt ← 0.
  - out_valid ← 0 on the same edge, discarding any held word.
  - in_ready is 0 in a load cycle.
- Output register is a two-state FSM:
  - EMPTY → FULL on transfer.
  - FULL → EMPTY on out_ready without a new transfer.
  - FULL → FULL on simultaneous out_ready and transfer, with the new word replacing the old.
- in_ready = !load & (!out_valid | out_ready), combinational.
- A stall holds state, outputs and counter unchanged.
- The step result must be identical for any W: W=8 over one word equals W=1 over 8 words.

## Timing
- Reset (rst low, async): state_out = 0, step_cnt = 0, out_valid = 0, out_data = 0, out_ks = 0.
  - All outputs hold these values while rst is low.
- Reset mid-operation discards any held word; the first edge after release may accept a word.
- Latency is 1 cycle: a word accepted at edge k has out_valid high after edge k, and state_out reflects all W steps after edge k.
- Throughput is 1 word per cycle while out_ready is high.
- out_data and out_ks are stable while out_valid & !out_ready.
- load and in_valid in the same cycle: load wins, the word is not consumed, and in_ready is 0.

## Test plan
- Zero state, W=1, encrypt, in_data=0, ca=cb=1, one transfer:
  - out_ks=0 and out_data=0.
  - state_out has only bit 292 set.
  - step_cnt=1.
- Zero state, W=8, encrypt, in_data=0x00:
  - state_out[292:285]=0xFF with all other bits 0.
  - out_ks=0x00 and step_cnt=8.
- Zero state, W=8, decrypt, in_data=0x5A:
  - out_data=0x5A.
  - state_out[292:285]=0xA5 with all other bits 0.
- Random loaded state with 200 random words, W=8 against W=1 fed bit-serially:
  - state_out, out_ks and out_data match bit-exactly after every word.
- Backpressure, W=8, zero state, in_data=0x00, out_ready low for 3 cycles after a transfer:
  - in_ready=0 and out_data/out_ks/state_out/step_cnt unchanged through the stall.
  - Next word accepted on the same edge out_ready rises.
  - With in_valid held high, exactly one out_valid word is delivered per accepted word.
- Reset and load checks:
  - rst low mid-stream gives immediate state_out=0, out_valid=0, step_cnt=0.
  - load concurrent with in_valid gives state_out=state_in, step_cnt=0, out_valid=0, and the word is not consumed.
